// File: rtl/opm_pkg.sv
// Shared definitions for the OPM write scheduler: FSM states, status bit positions
// and a small sizing helper.
package opm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP,
    S_DATA,
    S_SETTLE,
    S_POLL
  } state_t;

  localparam int BUSY = 7;
  localparam int IRQA = 0;
  localparam int IRQB = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding queued {register, data} pairs; reports occupancy and full.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  // Fullness is judged before any same-cycle pop, so a pop never makes room.
  assign o_full  = (r_level == L_FULL);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && (r_level != '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // NOTE: storage has no reset; the pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/opm_write_scheduler.sv
// Queues host register/data writes and replays them onto a slow OPM bus with
// the address-to-data gap, settle time and busy polling the chip needs.
module opm_write_scheduler
  import opm_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYC    = 14,
  parameter int SETTLE_CYC = 28,
  parameter int TMO_CYC    = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   host_wr_i,
  input  logic                   host_a0_i,
  input  logic [7:0]             host_d_i,
  output logic [7:0]             host_status_o,
  input  logic                   clr_flags_i,
  output logic                   ovf_o,
  output logic                   tmo_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   opm_cs_n_o,
  output logic                   opm_wr_n_o,
  output logic                   opm_a0_o,
  output logic [7:0]             opm_d_o,
  input  logic [7:0]             opm_status_i
);

  localparam int CNT_W = $clog2(max3(GAP_CYC, SETTLE_CYC, TMO_CYC)) + 1;
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TMO_CYC - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [7:0]           r_addr_hold;
  logic [7:0]           r_data_hold;
  logic                 r_ovf;
  logic                 r_tmo;
  logic                 r_cs_n;
  logic                 r_wr_n;
  logic                 r_a0;
  logic [7:0]           r_d;
  logic                 w_push_req;
  logic                 w_pop;
  logic                 w_full;
  logic [15:0]          w_head;
  logic [$clog2(DEPTH):0] w_level;
  logic                 w_unused_status;

  assign w_push_req      = host_wr_i && host_a0_i;
  assign w_pop           = (r_state == S_IDLE) && (w_level != '0);
  assign w_unused_status = &{1'b0, opm_status_i[6:2]};

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_wdata ({r_addr_hold, host_d_i}),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_hold <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (host_wr_i && !host_a0_i) r_addr_hold <= host_d_i;
      if (w_push_req && w_full)    r_ovf       <= 1'b1;
      else if (clr_flags_i)        r_ovf       <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_data_hold <= '0;
      r_tmo       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_a0        <= 1'b0;
      r_d         <= '0;
    end else begin
      // A timeout set later in this block overrides the clear.
      if (clr_flags_i) r_tmo <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_data_hold <= w_head[7:0];
            r_cs_n      <= 1'b0;
            r_wr_n      <= 1'b0;
            r_a0        <= 1'b0;
            r_d         <= w_head[15:8];
            r_state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_cs_n  <= 1'b1;
          r_wr_n  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_cs_n  <= 1'b0;
            r_wr_n  <= 1'b0;
            r_a0    <= 1'b1;
            r_d     <= r_data_hold;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          r_cs_n  <= 1'b1;
          r_wr_n  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt   <= '0;
            r_state <= S_POLL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_POLL: begin
          if (!opm_status_i[BUSY]) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_cnt == TMO_LAST) begin
            r_cnt   <= '0;
            r_tmo   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every bit gets a default first so this block can never infer a latch.
  always_comb begin
    host_status_o       = '0;
    host_status_o[BUSY] = w_full;
    host_status_o[IRQA] = opm_status_i[IRQA];
    host_status_o[IRQB] = opm_status_i[IRQB];
  end

  assign ovf_o      = r_ovf;
  assign tmo_o      = r_tmo;
  assign level_o    = w_level;
  assign opm_cs_n_o = r_cs_n;
  assign opm_wr_n_o = r_wr_n;
  assign opm_a0_o   = r_a0;
  assign opm_d_o    = r_d;

endmodule

// File: tb/tb_opm_write_scheduler.sv
// Directed and randomized checks of opm_write_scheduler against a queue-based
// model of the pairs the host has written and the bus timing they must produce.
`timescale 1ns/1ps
module tb_opm_write_scheduler;

  localparam int DEPTH      = 8;
  localparam int GAP_CYC    = 14;
  localparam int SETTLE_CYC = 28;
  localparam int TMO_CYC    = 4096;
  localparam int LW         = $clog2(DEPTH) + 1;
  localparam int PERIOD_MIN = 1 + GAP_CYC + 1 + SETTLE_CYC + 1 + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_wr_i = 1'b0;
  logic          host_a0_i = 1'b0;
  logic [7:0]    host_d_i = 8'h00;
  logic [7:0]    host_status_o;
  logic          clr_flags_i = 1'b0;
  logic          ovf_o;
  logic          tmo_o;
  logic [LW-1:0] level_o;
  logic          opm_cs_n_o;
  logic          opm_wr_n_o;
  logic          opm_a0_o;
  logic [7:0]    opm_d_o;
  logic [7:0]    opm_status_i = 8'h03;

  typedef struct {
    int         cyc;
    logic       a0;
    logic       wr_n;
    logic [7:0] d;
  } bus_ev_t;

  bus_ev_t     q_bus[$];
  logic [15:0] m_exp[$];
  logic [7:0]  m_addr = 8'h00;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          rand_busy = 1'b0;

  opm_write_scheduler #(
    .DEPTH      (DEPTH),
    .GAP_CYC    (GAP_CYC),
    .SETTLE_CYC (SETTLE_CYC),
    .TMO_CYC    (TMO_CYC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host_wr_i     (host_wr_i),
    .host_a0_i     (host_a0_i),
    .host_d_i      (host_d_i),
    .host_status_o (host_status_o),
    .clr_flags_i   (clr_flags_i),
    .ovf_o         (ovf_o),
    .tmo_o         (tmo_o),
    .level_o       (level_o),
    .opm_cs_n_o    (opm_cs_n_o),
    .opm_wr_n_o    (opm_wr_n_o),
    .opm_a0_o      (opm_a0_o),
    .opm_d_o       (opm_d_o),
    .opm_status_i  (opm_status_i)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && !opm_cs_n_o) q_bus.push_back('{cyc, opm_a0_o, opm_wr_n_o, opm_d_o});
  end

  always @(negedge clk) begin
    if (rand_busy) begin
      opm_status_i[7]   = 1'($urandom_range(0, 1));
      opm_status_i[1:0] = 2'($urandom_range(0, 3));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives one write cycle and records what the host intends.
  task automatic host_write(input logic a0, input logic [7:0] d, input bit accept = 1'b1);
    host_wr_i = 1'b1;
    host_a0_i = a0;
    host_d_i  = d;
    if (!a0)         m_addr = d;
    else if (accept) m_exp.push_back({m_addr, d});
    @(negedge clk);
    host_wr_i = 1'b0;
    host_a0_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_events(input int n, input int budget, input string tag);
    int k = 0;
    while (q_bus.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(q_bus.size() >= n), 32'd1);
  endtask

  task automatic check_pairs(input int n, input bit chk_period);
    int prev = -1;
    bus_ev_t ea, ed;
    logic [15:0] exp;
    for (int i = 0; i < n; i++) begin
      if (q_bus.size() < 2 || m_exp.size() == 0) begin
        check("pair_available", 32'd0, 32'd1);
        return;
      end
      ea  = q_bus.pop_front();
      ed  = q_bus.pop_front();
      exp = m_exp.pop_front();
      check("addr_strobe_a0", 32'(ea.a0), 32'd0);
      check("addr_strobe_wr_n", 32'(ea.wr_n), 32'd0);
      check("addr_strobe_d", 32'(ea.d), 32'(exp[15:8]));
      check("data_strobe_a0", 32'(ed.a0), 32'd1);
      check("data_strobe_wr_n", 32'(ed.wr_n), 32'd0);
      check("data_strobe_d", 32'(ed.d), 32'(exp[7:0]));
      check("addr_to_data_gap", 32'(ed.cyc - ea.cyc), 32'(GAP_CYC + 1));
      if (chk_period && prev >= 0) check("pair_period", 32'(ea.cyc - prev), 32'(PERIOD_MIN));
      prev = ea.cyc;
    end
  endtask

  initial begin
    int c0, d0, t, k, n_pairs;

    // Reset state
    idle(2);
    check("rst_cs_n", 32'(opm_cs_n_o), 32'd1);
    check("rst_wr_n", 32'(opm_wr_n_o), 32'd1);
    check("rst_a0", 32'(opm_a0_o), 32'd0);
    check("rst_d", 32'(opm_d_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_tmo", 32'(tmo_o), 32'd0);
    check("rst_host_status", 32'(host_status_o), 32'h03);
    reset = 1'b0;
    @(negedge clk);

    // Single pair: address strobe, then data strobe GAP_CYC+1 cycles later
    opm_status_i = 8'h00;
    host_write(1'b0, 8'h28);
    c0 = cyc;
    host_write(1'b1, 8'h4A);
    wait_events(2, 100, "first_pair_seen");
    check("first_addr_latency", (q_bus.size() > 0) ? 32'(q_bus[0].cyc - c0) : 32'hFFFF_FFFF, 32'd2);
    check_pairs(1, 1'b0);
    idle(60);
    check("first_level_drained", 32'(level_o), 32'd0);

    // Address reuse across repeated data writes, back-to-back at minimum period
    host_write(1'b0, 8'h08);
    host_write(1'b1, 8'h01);
    host_write(1'b1, 8'h02);
    host_write(1'b1, 8'h03);
    wait_events(6, 400, "reuse_pairs_seen");
    check_pairs(3, 1'b1);
    idle(60);

    // Randomized rounds; at most DEPTH pairs outstanding so nothing is dropped
    for (int r = 0; r < 4; r++) begin
      rand_busy = 1'b1;
      n_pairs = $urandom_range(1, DEPTH);
      for (int i = 0; i < n_pairs; i++) begin
        if ($urandom_range(0, 2) != 0) host_write(1'b0, 8'($urandom));
        host_write(1'b1, 8'($urandom));
        idle($urandom_range(0, 2));
      end
      wait_events(2 * n_pairs, n_pairs * 300, "rand_pairs_seen");
      check_pairs(n_pairs, 1'b0);
      rand_busy = 1'b0;
      opm_status_i = 8'h01;
      idle(100);
      check("rand_level", 32'(level_o), 32'd0);
      check("rand_ovf", 32'(ovf_o), 32'd0);
      check("rand_tmo", 32'(tmo_o), 32'd0);
      check("rand_host_status", 32'(host_status_o), 32'h01);
    end

    // Overflow: one pair in flight with busy stuck, then nine more pairs
    opm_status_i = 8'h81;
    host_write(1'b0, 8'hA0);
    host_write(1'b1, 8'h00);
    wait_events(2, 100, "p0_seen");
    d0 = (q_bus.size() >= 2) ? q_bus[1].cyc : 0;
    for (int i = 0; i < 9; i++) begin
      host_write(1'b0, 8'(8'h10 + i));
      host_write(1'b1, 8'(8'h20 + i), i < DEPTH);
    end
    check("ovf_level_full", 32'(level_o), 32'(DEPTH));
    check("ovf_flag", 32'(ovf_o), 32'd1);
    check("ovf_host_status", 32'(host_status_o), 32'h81);
    clr_flags_i = 1'b1;
    @(negedge clk);
    clr_flags_i = 1'b0;
    check("ovf_cleared", 32'(ovf_o), 32'd0);
    clr_flags_i = 1'b1;
    host_write(1'b1, 8'h99, 1'b0);
    clr_flags_i = 1'b0;
    check("ovf_set_beats_clear", 32'(ovf_o), 32'd1);
    check("ovf_level_still_full", 32'(level_o), 32'(DEPTH));

    // Busy timeout, then the next pair issues immediately
    k = 0;
    while (!tmo_o && k < TMO_CYC + 200) begin
      @(negedge clk);
      k++;
    end
    t = cyc;
    check("tmo_latency", 32'(t - d0), 32'(1 + SETTLE_CYC + TMO_CYC));
    opm_status_i = 8'h02;
    clr_flags_i  = 1'b1;
    @(negedge clk);
    clr_flags_i  = 1'b0;
    check("tmo_cleared", 32'(tmo_o), 32'd0);
    check("ovf_cleared_again", 32'(ovf_o), 32'd0);
    wait_events(3, 10, "p1_seen");
    check("p1_after_tmo", (q_bus.size() >= 3) ? 32'(q_bus[2].cyc) : 32'hFFFF_FFFF, 32'(t + 1));

    // Push on the cycle the scheduler pops with level at DEPTH-1
    while (cyc < t + PERIOD_MIN) @(negedge clk);
    check("level_before_pushpop", 32'(level_o), 32'(DEPTH - 1));
    host_write(1'b1, 8'h55);
    check("level_after_pushpop", 32'(level_o), 32'(DEPTH - 1));
    check("no_ovf_pushpop", 32'(ovf_o), 32'd0);
    wait_events(20, 10 * PERIOD_MIN + 200, "drain_seen");
    check_pairs(2, 1'b0);
    check_pairs(8, 1'b1);
    idle(60);
    check("drain_level", 32'(level_o), 32'd0);

    // Reset during GAP aborts the transaction and empties the queue
    opm_status_i = 8'h00;
    host_write(1'b0, 8'h33);
    host_write(1'b1, 8'h44);
    host_write(1'b1, 8'h45);
    wait_events(1, 20, "gap_addr_seen");
    idle(5);
    reset = 1'b1;
    #1;
    check("midrst_cs_n", 32'(opm_cs_n_o), 32'd1);
    check("midrst_wr_n", 32'(opm_wr_n_o), 32'd1);
    check("midrst_level", 32'(level_o), 32'd0);
    check("midrst_d", 32'(opm_d_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_exp.delete();
    m_addr = 8'h00;
    idle(80);
    check("midrst_no_more_strobes", 32'(q_bus.size()), 32'd1);
    q_bus.delete();

    // Address hold was cleared by reset
    host_write(1'b1, 8'h77);
    wait_events(2, 100, "post_rst_pair_seen");
    check_pairs(1, 1'b0);
    idle(60);
    check("final_level", 32'(level_o), 32'd0);
    check("final_tmo", 32'(tmo_o), 32'd0);
    check("final_no_stray_strobes", 32'(q_bus.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opm_write_scheduler.md
OPM_WRITE_SCHEDULER -- requirements
Module: opm_write_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in register/data pairs (power of 2, 2..64).
REQ-002 SHALL have parameter GAP_CYC, default 14, idle cycles between address strobe and data strobe.
REQ-003 SHALL have parameter SETTLE_CYC, default 28, cycles after data strobe before busy polling starts.
REQ-004 SHALL have parameter TMO_CYC, default 4096, busy-wait timeout in cycles.
REQ-005 SHALL have port clk  in  1  system clock, 48 MHz.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port host_wr_i  in  1  one-cycle host write strobe.
REQ-008 SHALL have port host_a0_i  in  1  host A0: 0 = register address, 1 = register data.
REQ-009 SHALL have port host_d_i  in  8  host write data.
REQ-010 SHALL have port host_status_o  out  8  emulated OPM status for host reads.
REQ-011 SHALL have port clr_flags_i  in  1  one-cycle clear of sticky flags.
REQ-012 SHALL have port ovf_o  out  1  sticky FIFO-overflow flag.
REQ-013 SHALL have port tmo_o  out  1  sticky busy-timeout flag.
REQ-014 SHALL have port level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 SHALL have ports opm_cs_n_o, opm_wr_n_o, opm_a0_o  out  1 each  OPM bus strobes.
REQ-016 SHALL have port opm_d_o  out  8  OPM write data.
REQ-017 SHALL have port opm_status_i  in  8  live OPM status byte; bit 7 = busy.

Function
REQ-018 SHALL latch host_d_i into an address-hold register on host_wr_i with host_a0_i=0; no push.
REQ-019 SHALL push {addr_hold, host_d_i} on host_wr_i with host_a0_i=1 when level_o<DEPTH.
REQ-020 SHALL drop the write and set ovf_o when host_wr_i with host_a0_i=1 arrives at level_o==DEPTH; a same-cycle pop does not make room.
REQ-021 SHALL leave addr_hold unchanged after a push, so repeated data writes reuse the last address.
REQ-022 SHALL apply a same-cycle push and pop with level_o unchanged; pointers wrap modulo DEPTH.
REQ-023 SHALL run FSM IDLE -> ADDR -> GAP -> DATA -> SETTLE -> POLL -> IDLE.
REQ-024 IDLE SHALL pop the FIFO head into a working register and enter ADDR when level_o>0.
REQ-025 ADDR SHALL drive cs_n=0, wr_n=0, a0=0, d=addr for exactly one cycle.
REQ-026 GAP SHALL hold cs_n=1 for GAP_CYC cycles.
REQ-027 DATA SHALL drive cs_n=0, wr_n=0, a0=1, d=data for exactly one cycle.
REQ-028 SETTLE SHALL count SETTLE_CYC cycles and ignore opm_status_i.
REQ-029 POLL SHALL return to IDLE on the first cycle with opm_status_i[7]=0.
REQ-030 POLL SHALL set tmo_o and return to IDLE after TMO_CYC cycles with bit 7 still 1.
REQ-031 Outside ADDR and DATA, strobes SHALL be cs_n=1, wr_n=1; a0 and d hold their last values.
REQ-032 SHALL drive host_status_o[7] = (level_o==DEPTH), host_status_o[1:0] = opm_status_i[1:0], and other bits 0.
REQ-033 clr_flags_i SHALL clear ovf_o and tmo_o; a same-cycle set wins.
REQ-034 Minimum pair issue period SHALL be 1+GAP_CYC+1+SETTLE_CYC+1 (POLL) +1 (IDLE) cycles.

Reset
REQ-035 While reset is high: FSM=IDLE, FIFO empty (level_o=0), addr_hold=0, ovf_o=0, tmo_o=0, cs_n=1, wr_n=1, a0=0, d=0, all counters 0.
REQ-036 Reset mid-transaction SHALL abort immediately with no further strobe; queued pairs are lost.

Structure
REQ-037 SHALL use a shared package opm_pkg holding the FSM state enum and the OPM status bit index constants (BUSY=7, IRQA=0, IRQB=1).
REQ-038 SHALL use one sub-module, sync_fifo (parameter WIDTH=16, DEPTH), containing storage, pointers and level.

Verification
REQ-039 Reset, then A0=0 0x28 and A0=1 0x4A -> ADDR strobe d=0x28 a0=0, 15 cycles later DATA strobe d=0x4A a0=1.
REQ-040 Push 9 pairs back-to-back with DEPTH=8 and opm busy held at 1 -> level_o=8, ovf_o=1, host_status_o[7]=1, ninth pair never issued.
REQ-041 Hold opm_status_i[7]=1 beyond TMO_CYC -> tmo_o=1 exactly TMO_CYC POLL cycles later, next pair issues; then pulse clr_flags_i -> tmo_o=0.
REQ-042 Write address 0x08 then data 0x01, 0x02, 0x03 -> three pairs issued as (0x08,0x01), (0x08,0x02), (0x08,0x03) in order.
REQ-043 Assert reset during GAP -> no DATA strobe occurs, level_o=0, cs_n=1 within the same cycle.
REQ-044 Push while a pop occurs with level_o=DEPTH-1 -> level_o stays DEPTH-1 and no overflow.
